execute_memory_reg: RTL and testbench
=====================================

// Module: execute_memory_reg
// PURPOSE
//  E->M pipeline register plus condition-code (CC) register for the pipelined Y86-64 core.
//  Sits at the receiving end of the execute stage. Captures e_valE, e_cnd, e_dstE and the
//  pass-through fields (stat, icode, valA, dstM) on each clock, giving the memory stage its
//  M_* inputs. Holds ZF/SF/OF and feeds them back to execute for cmov/jXX evaluation.
// PARAMETERS
//  WIDTH  64    data-path width of valE/valA
//  RNONE  4'hF  register ID meaning "no destination"
//  INOP   4'h1  icode inserted for a bubble
//  SAOK   3'd1  normal status code; any other stat value is exceptional
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  M_stall    in   1      hold all M_* registers this cycle
//  M_bubble   in   1      load a bubble into M_* this cycle
//  e_stat     in   3      status from execute
//  e_icode    in   4      icode from execute
//  e_cnd      in   1      condition result from execute (X allowed when icode is not 2/7)
//  e_valE     in   WIDTH  ALU result
//  e_valA     in   WIDTH  valA pass-through
//  e_dstE     in   4      destination E (already RNONE if a cmov fails)
//  e_dstM     in   4      destination M
//  e_set_cc   in   1      execute requests a CC update (OPq)
//  e_zf,e_sf,e_of in 1    new flag values computed by execute
//  m_stat     in   3      status produced by the memory stage this cycle
//  W_stat     in   3      status held in the write-back register
//  M_stat     out  3      registered stat
//  M_icode    out  4      registered icode
//  M_cnd      out  1      registered condition
//  M_valE     out  WIDTH  registered ALU result
//  M_valA     out  WIDTH  registered valA
//  M_dstE     out  4      registered dstE
//  M_dstM     out  4      registered dstM
//  cc_zf,cc_sf,cc_of out 1  current CC register contents
// BEHAVIOUR
//  Reset (async, takes effect immediately, including mid-operation):
//   - M_* registers take the bubble state: stat=SAOK, icode=INOP, cnd=0, valE=0, valA=0,
//     dstE=dstM=RNONE.
//   - CC takes ZF=1, SF=0, OF=0.
//  Pipeline register, updated on the rising clock edge, priority highest first:
//   - M_stall=1: all M_* hold. This overrides M_bubble.
//   - M_bubble=1: load the bubble state (same values as reset).
//   - Otherwise: load all e_* fields. Latency is exactly 1 cycle.
//   - e_cnd is sanitised: an X/Z input is stored as 0. M_cnd is never X after reset.
//  CC register, updated on the rising clock edge:
//   - Updates only when all of these hold: e_set_cc=1; m_stat==SAOK; W_stat==SAOK;
//     M_stall=0.
//   - On update, ZF/SF/OF load e_zf/e_sf/e_of together, with no partial updates.
//   - Otherwise CC holds. An exception in M or W therefore freezes the flags, so a faulting
//     older instruction cannot be followed by visible CC changes.
//   - CC is independent of M_bubble: a bubble into M does not block a legitimate OPq in E.
//  Output timing:
//   - All outputs are registered, with no combinational paths from inputs to outputs.
//   - cc_* is visible to execute in the cycle after the OPq leaves E.
//  No internal state machine beyond these registers. WIDTH-wide fields are copied
//  bit-exactly, with no sign handling.
// TESTING
//  1. Pass-through:
//     assert rst, then release; drive e_icode=6, e_valE=64'h10, e_dstE=3, e_stat=1
//     -> after 1 edge M_icode=6, M_valE=64'h10, M_dstE=3, M_stat=1.
//  2. Bubble:
//     drive M_bubble=1 with e_icode=3 -> next edge M_icode=1, M_dstE=M_dstM=4'hF,
//     M_cnd=0, M_valE=0.
//  3. Stall beats bubble:
//     load M_valE=64'h55, then M_stall=1 and M_bubble=1 for 3 cycles
//     -> M_valE stays 64'h55 and M_icode is unchanged.
//  4. CC update:
//     e_set_cc=1, e_zf=0, e_sf=1, e_of=1, m_stat=W_stat=1
//     -> next edge cc_zf=0, cc_sf=1, cc_of=1; with e_set_cc=0 afterwards the flags hold.
//  5. CC blocked by exception:
//     with m_stat=3 (SINS), or W_stat=2 (SADR), and e_set_cc=1, e_zf=0
//     -> cc_zf keeps its old value (1 after reset).
//  6. Async reset mid-stream:
//     assert rst between edges while M_valE=64'hFF and cc_zf=0
//     -> immediately M_valE=0, M_icode=1, cc_zf=1; X on e_cnd never propagates to M_cnd.

Source files
------------

// File: rtl/execute_memory_reg.sv
// E->M pipeline register and condition-code register for the pipelined Y86-64 core.
// Captures execute results for the memory stage and holds the ZF/SF/OF flags fed back to execute.
module execute_memory_reg #(
    parameter int unsigned WIDTH = 64,
    parameter logic [3:0]  RNONE = 4'hF,
    parameter logic [3:0]  INOP  = 4'h1,
    parameter logic [2:0]  SAOK  = 3'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             M_stall,
    input  logic             M_bubble,
    input  logic [2:0]       e_stat,
    input  logic [3:0]       e_icode,
    input  logic             e_cnd,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [WIDTH-1:0] e_valA,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             e_set_cc,
    input  logic             e_zf,
    input  logic             e_sf,
    input  logic             e_of,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic [2:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef struct packed {
        logic [2:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] valE;
        logic [WIDTH-1:0] valA;
        logic [3:0]       dstE;
        logic [3:0]       dstM;
    } m_reg_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam m_reg_t BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        cnd:   1'b0,
        valE:  '0,
        valA:  '0,
        dstE:  RNONE,
        dstM:  RNONE
    };
    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    m_reg_t m_q;
    m_reg_t e_fields;
    cc_t    cc_q;
    logic   cnd_clean;
    logic   cc_en;

    // cnd is only meaningful for cmov/jXX; anything other than a clean 1 is stored as 0
    assign cnd_clean = (e_cnd === 1'b1);

    always_comb begin
        e_fields       = BUBBLE;
        e_fields.stat  = e_stat;
        e_fields.icode = e_icode;
        e_fields.cnd   = cnd_clean;
        e_fields.valE  = e_valE;
        e_fields.valA  = e_valA;
        e_fields.dstE  = e_dstE;
        e_fields.dstM  = e_dstM;
    end

    // Exceptions in M or W freeze the flags so a faulting older instruction hides later OPq effects
    assign cc_en = e_set_cc && (m_stat == SAOK) && (W_stat == SAOK) && !M_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= BUBBLE;
        end else if (!M_stall) begin
            m_q <= M_bubble ? BUBBLE : e_fields;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else if (cc_en) begin
            cc_q <= '{zf: e_zf, sf: e_sf, of: e_of};
        end
    end

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_cnd   = m_q.cnd;
    assign M_valE  = m_q.valE;
    assign M_valA  = m_q.valA;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;
    assign cc_zf   = cc_q.zf;
    assign cc_sf   = cc_q.sf;
    assign cc_of   = cc_q.of;

endmodule

// File: tb/tb_execute_memory_reg.sv
// Bench for execute_memory_reg: directed scenarios followed by randomized traffic,
// all checked against a rule-level model of the pipeline and CC registers.
module tb_execute_memory_reg;

    localparam int unsigned WIDTH = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             M_stall, M_bubble;
    logic [2:0]       e_stat;
    logic [3:0]       e_icode;
    logic             e_cnd;
    logic [WIDTH-1:0] e_valE, e_valA;
    logic [3:0]       e_dstE, e_dstM;
    logic             e_set_cc, e_zf, e_sf, e_of;
    logic [2:0]       m_stat, W_stat;
    logic [2:0]       M_stat;
    logic [3:0]       M_icode;
    logic             M_cnd;
    logic [WIDTH-1:0] M_valE, M_valA;
    logic [3:0]       M_dstE, M_dstM;
    logic             cc_zf, cc_sf, cc_of;

    int passed = 0;
    int total  = 0;

    // Reference state
    logic [2:0]       x_stat;
    logic [3:0]       x_icode;
    logic             x_cnd;
    logic [WIDTH-1:0] x_valE, x_valA;
    logic [3:0]       x_dstE, x_dstM;
    logic             x_zf, x_sf, x_of;

    execute_memory_reg dut (
        .clk(clk), .rst(rst), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd), .e_valE(e_valE),
        .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM), .e_set_cc(e_set_cc),
        .e_zf(e_zf), .e_sf(e_sf), .e_of(e_of), .m_stat(m_stat), .W_stat(W_stat),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    task automatic model_bubble();
        x_stat = 3'd1; x_icode = 4'h1; x_cnd = 1'b0;
        x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
    endtask

    task automatic model_reset();
        model_bubble();
        x_zf = 1'b1; x_sf = 1'b0; x_of = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".stat"},  64'(M_stat),  64'(x_stat));
        check({tag, ".icode"}, 64'(M_icode), 64'(x_icode));
        check({tag, ".cnd"},   64'(M_cnd),   64'(x_cnd));
        check({tag, ".valE"},  M_valE,       x_valE);
        check({tag, ".valA"},  M_valA,       x_valA);
        check({tag, ".dstE"},  64'(M_dstE),  64'(x_dstE));
        check({tag, ".dstM"},  64'(M_dstM),  64'(x_dstM));
        check({tag, ".cc"},    64'({cc_zf, cc_sf, cc_of}), 64'({x_zf, x_sf, x_of}));
    endtask

    // Apply the register rules to the inputs present before the edge, then clock and compare
    task automatic step(input string tag);
        if (!M_stall) begin
            if (M_bubble) model_bubble();
            else begin
                x_stat = e_stat; x_icode = e_icode; x_cnd = (e_cnd === 1'b1);
                x_valE = e_valE; x_valA = e_valA; x_dstE = e_dstE; x_dstM = e_dstM;
            end
        end
        if (e_set_cc && m_stat == 3'd1 && W_stat == 3'd1 && !M_stall) begin
            x_zf = e_zf; x_sf = e_sf; x_of = e_of;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; M_stall = 0; M_bubble = 0;
        e_stat = 3'd1; e_icode = 4'h0; e_cnd = 0; e_valE = '0; e_valA = '0;
        e_dstE = 4'hF; e_dstM = 4'hF; e_set_cc = 0; e_zf = 0; e_sf = 0; e_of = 0;
        m_stat = 3'd1; W_stat = 3'd1;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // Pass-through
        e_icode = 4'h6; e_valE = 64'h10; e_dstE = 4'h3; e_stat = 3'd1;
        step("pass");
        check("pass.icode_const", 64'(M_icode), 64'h6);
        check("pass.valE_const", M_valE, 64'h10);

        // Bubble
        M_bubble = 1; e_icode = 4'h3; e_valE = 64'h77; e_cnd = 1;
        step("bubble");
        check("bubble.icode_const", 64'(M_icode), 64'h1);
        check("bubble.dstM_const", 64'(M_dstM), 64'hF);

        // Stall beats bubble
        M_bubble = 0; e_icode = 4'h6; e_valE = 64'h55;
        step("load55");
        M_stall = 1; M_bubble = 1; e_icode = 4'h2; e_valE = 64'h99;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.valE_const", M_valE, 64'h55);
        check("stall.icode_const", 64'(M_icode), 64'h6);

        // CC update and hold
        M_stall = 0; M_bubble = 0;
        e_set_cc = 1; e_zf = 0; e_sf = 1; e_of = 1;
        step("cc_set");
        check("cc_set.const", 64'({cc_zf, cc_sf, cc_of}), 64'b011);
        e_set_cc = 0; e_zf = 1; e_sf = 0; e_of = 0;
        step("cc_hold");
        check("cc_hold.const", 64'({cc_zf, cc_sf, cc_of}), 64'b011);

        // CC blocked by exceptions in M or W, and by a stall
        e_set_cc = 1; e_zf = 1; e_sf = 0; e_of = 0;
        step("cc_zf1");
        e_zf = 0; e_sf = 1; m_stat = 3'd3;
        step("cc_m_exc");
        check("cc_m_exc.zf_const", 64'(cc_zf), 64'h1);
        m_stat = 3'd1; W_stat = 3'd2;
        step("cc_w_exc");
        check("cc_w_exc.zf_const", 64'(cc_zf), 64'h1);
        W_stat = 3'd1; M_stall = 1;
        step("cc_stall");
        M_stall = 0; M_bubble = 1;
        step("cc_with_bubble");
        check("cc_with_bubble.zf_const", 64'(cc_zf), 64'h0);

        // Async reset between edges
        M_bubble = 0; e_valE = 64'hFF; e_set_cc = 1; e_zf = 0;
        step("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.valE_const", M_valE, 64'h0);
        #1;
        rst = 1'b0;
        e_set_cc = 0; e_cnd = 1'bx; e_icode = 4'h6;
        step("cnd_x");
        check("cnd_x.const", 64'(M_cnd), 64'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            M_stall  = ($urandom_range(0, 4) == 0);
            M_bubble = ($urandom_range(0, 4) == 0);
            e_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd1;
            e_icode  = 4'($urandom);
            e_cnd    = 1'($urandom);
            e_valE   = {$urandom, $urandom};
            e_valA   = {$urandom, $urandom};
            e_dstE   = 4'($urandom);
            e_dstM   = 4'($urandom);
            e_set_cc = 1'($urandom);
            e_zf = 1'($urandom); e_sf = 1'($urandom); e_of = 1'($urandom);
            m_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            W_stat   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
